// File: rtl/cas_sort_ctrl.sv
// Batch sorter: loads NUM_ELEM words, bubble-sorts them largest-first with one
// shared compare-and-swap per cycle, then streams them out with valid/ready.
module cas_sort_ctrl #(
   parameter int SNG_WIDTH = 6,
   parameter int NUM_ELEM  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [SNG_WIDTH-1:0] in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [SNG_WIDTH-1:0] out_data,
   input  logic                 out_ready,
   output logic                 busy
);

   localparam int IW = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ELEM - 1);
   localparam logic [IW-1:0] LAST_CMP = IW'(NUM_ELEM - 2);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_SORT,
      ST_DRAIN
   } state_t;

   state_t               r_state;
   logic [IW-1:0]        r_load_idx;
   logic [IW-1:0]        r_i;
   logic [IW-1:0]        r_pass;
   logic [IW-1:0]        r_out_idx;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic                 r_busy;

   logic [SNG_WIDTH-1:0] w_elem [NUM_ELEM];
   logic [IW-1:0]        w_i_nxt;
   logic [SNG_WIDTH-1:0] w_cmp_a;
   logic [SNG_WIDTH-1:0] w_cmp_b;
   logic [SNG_WIDTH:0]   w_diff;
   logic                 w_swap;
   logic                 w_load_fire;
   logic                 w_sort_step;

   assign w_i_nxt = r_i + IW'(1);
   assign w_cmp_a = w_elem[r_i];
   assign w_cmp_b = w_elem[w_i_nxt];

   // Borrow out of the widened subtract means a < b; ties leave the pair alone,
   // which keeps equal keys in load order.
   assign w_diff = {1'b0, w_cmp_a} - {1'b0, w_cmp_b};
   assign w_swap = w_diff[SNG_WIDTH];

   assign w_load_fire = (r_state == ST_LOAD) && in_valid;
   assign w_sort_step = (r_state == ST_SORT);

   generate
      for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_elem
         logic [SNG_WIDTH-1:0] r_word;

         always_ff @(posedge clk) begin
            if (!rst) begin
               if (w_load_fire && (r_load_idx == IW'(gi))) begin
                  r_word <= in_data;
               end else if (w_sort_step && w_swap) begin
                  if (r_i == IW'(gi)) begin
                     r_word <= w_cmp_b;
                  end else if (w_i_nxt == IW'(gi)) begin
                     r_word <= w_cmp_a;
                  end
               end
            end
         end

         assign w_elem[gi] = r_word;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_LOAD;
         r_load_idx  <= '0;
         r_i         <= '0;
         r_pass      <= '0;
         r_out_idx   <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (in_valid) begin
                  if (r_load_idx == LAST_IDX) begin
                     r_state    <= ST_SORT;
                     r_load_idx <= '0;
                     r_i        <= '0;
                     r_pass     <= '0;
                     r_in_ready <= 1'b0;
                     r_busy     <= 1'b1;
                  end else begin
                     r_load_idx <= r_load_idx + IW'(1);
                  end
               end
            end
            ST_SORT: begin
               // Fixed (NUM_ELEM-1)^2 schedule: no early exit on a sorted batch.
               if (r_i == LAST_CMP) begin
                  r_i <= '0;
                  if (r_pass == LAST_CMP) begin
                     r_state     <= ST_DRAIN;
                     r_pass      <= '0;
                     r_out_idx   <= '0;
                     r_busy      <= 1'b0;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_pass <= r_pass + IW'(1);
                  end
               end else begin
                  r_i <= w_i_nxt;
               end
            end
            ST_DRAIN: begin
               if (out_ready) begin
                  if (r_out_idx == LAST_IDX) begin
                     r_state     <= ST_LOAD;
                     r_out_idx   <= '0;
                     r_load_idx  <= '0;
                     r_out_valid <= 1'b0;
                     r_in_ready  <= 1'b1;
                  end else begin
                     r_out_idx <= r_out_idx + IW'(1);
                  end
               end
            end
            default: begin
               r_state     <= ST_LOAD;
               r_load_idx  <= '0;
               r_i         <= '0;
               r_pass      <= '0;
               r_out_idx   <= '0;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign out_data  = w_elem[r_out_idx];

endmodule

// File: tb/tb_cas_sort_ctrl.sv
// Directed bench for cas_sort_ctrl: loads hand-picked batches and checks
// sorted order, latency, stall behaviour, mid-sort reset and back-to-back loads.
module tb_cas_sort_ctrl;

   localparam int W = 6;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready;
   logic         busy;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] got [N];
   int           n_got;
   int           hold_err;
   int           ir_err;
   int           lat;
   int           busy_n;

   always #5 clk = ~clk;

   cas_sort_ctrl #(.SNG_WIDTH(W), .NUM_ELEM(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy)
   );

   // Presents four words on consecutive cycles; caller must be at a negedge in LOAD.
   task automatic load4(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d);
      logic [W-1:0] v [N];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int k = 0; k < N; k++) begin
         if (k > 0) @(negedge clk);
         in_valid = 1'b1;
         in_data  = v[k];
      end
   endtask

   // Counts cycles from the last-word cycle until out_valid rises, and busy cycles.
   task automatic run_sort(input bit keep, input logic [W-1:0] nxt);
      lat    = 0;
      busy_n = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (keep) in_data = nxt;
         else      in_valid = 1'b0;
         lat++;
         if (busy === 1'b1) busy_n++;
         if (out_valid === 1'b1) break;
      end
   endtask

   // Collects four outputs with out_ready following pat (bit 0 first, repeating).
   task automatic drain(input logic [3:0] pat);
      logic         stalled;
      logic [W-1:0] prev;
      n_got    = 0;
      hold_err = 0;
      ir_err   = 0;
      stalled  = 1'b0;
      prev     = '0;
      for (int c = 0; c < 60 && n_got < N; c++) begin
         if (c > 0) @(negedge clk);
         if (stalled && (out_data !== prev)) hold_err++;
         if (in_ready !== 1'b0) ir_err++;
         if (out_valid === 1'b1) begin
            out_ready = pat[c % 4];
            if (out_ready) begin
               got[n_got] = out_data;
               n_got++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               prev    = out_data;
            end
         end else begin
            out_ready = 1'b1;
            stalled   = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
      $display("test_reset: in_ready=%b out_valid=%b busy=%b", in_ready, out_valid, busy);
   endtask

   task automatic test_batch(input string name,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d,
                             input logic [W-1:0] e0, input logic [W-1:0] e1,
                             input logic [W-1:0] e2, input logic [W-1:0] e3);
      logic [W-1:0] ex [N];
      ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
      @(negedge clk);
      load4(a, b, c, d);
      run_sort(1'b0, '0);
      total++; if (lat !== 10) begin bad++; $display("FAIL %s_latency got=%0d exp=10", name, lat); end
      total++; if (busy_n !== 9) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=9", name, busy_n); end
      drain(4'b1111);
      total++; if (n_got !== N) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", name, n_got, N); end
      for (int k = 0; k < n_got; k++) begin
         total++;
         if (got[k] !== ex[k]) begin bad++; $display("FAIL %s_out%0d got=%0d exp=%0d", name, k, got[k], ex[k]); end
      end
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_back_to_load got=%b exp=1", name, in_ready); end
      $display("%s: in=%0d,%0d,%0d,%0d out=%0d,%0d,%0d,%0d lat=%0d busy=%0d",
               name, a, b, c, d, got[0], got[1], got[2], got[3], lat, busy_n);
   endtask

   task automatic test_stall();
      @(negedge clk);
      load4(6'd5, 6'd17, 6'd33, 6'd2);
      run_sort(1'b0, '0);
      drain(4'b1001);
      total++; if (n_got !== N) begin bad++; $display("FAIL stall_count got=%0d exp=4", n_got); end
      total++; if (hold_err !== 0) begin bad++; $display("FAIL stall_hold got=%0d exp=0", hold_err); end
      total++; if (ir_err !== 0) begin bad++; $display("FAIL stall_in_ready got=%0d exp=0", ir_err); end
      total++; if (got[0] !== 6'd33) begin bad++; $display("FAIL stall_out0 got=%0d exp=33", got[0]); end
      total++; if (got[1] !== 6'd17) begin bad++; $display("FAIL stall_out1 got=%0d exp=17", got[1]); end
      total++; if (got[2] !== 6'd5) begin bad++; $display("FAIL stall_out2 got=%0d exp=5", got[2]); end
      total++; if (got[3] !== 6'd2) begin bad++; $display("FAIL stall_out3 got=%0d exp=2", got[3]); end
      @(negedge clk);
      out_ready = 1'b1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_back_to_load got=%b exp=1", in_ready); end
      $display("test_stall: out=%0d,%0d,%0d,%0d hold_err=%0d", got[0], got[1], got[2], got[3], hold_err);
   endtask

   task automatic test_abort();
      @(negedge clk);
      load4(6'd10, 6'd20, 6'd30, 6'd40);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
      load4(6'd7, 6'd9, 6'd8, 6'd1);
      run_sort(1'b0, '0);
      total++; if (lat !== 10) begin bad++; $display("FAIL abort_latency got=%0d exp=10", lat); end
      drain(4'b1111);
      total++; if (got[0] !== 6'd9) begin bad++; $display("FAIL abort_out0 got=%0d exp=9", got[0]); end
      total++; if (got[1] !== 6'd8) begin bad++; $display("FAIL abort_out1 got=%0d exp=8", got[1]); end
      total++; if (got[2] !== 6'd7) begin bad++; $display("FAIL abort_out2 got=%0d exp=7", got[2]); end
      total++; if (got[3] !== 6'd1) begin bad++; $display("FAIL abort_out3 got=%0d exp=1", got[3]); end
      @(negedge clk);
      $display("test_abort: out=%0d,%0d,%0d,%0d", got[0], got[1], got[2], got[3]);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      load4(6'd12, 6'd45, 6'd45, 6'd7);
      run_sort(1'b1, 6'd33);
      drain(4'b1111);
      total++; if (ir_err !== 0) begin bad++; $display("FAIL b2b_in_ready_drain got=%0d exp=0", ir_err); end
      total++; if (got[0] !== 6'd45) begin bad++; $display("FAIL b2b_a_out0 got=%0d exp=45", got[0]); end
      total++; if (got[1] !== 6'd45) begin bad++; $display("FAIL b2b_a_out1 got=%0d exp=45", got[1]); end
      total++; if (got[2] !== 6'd12) begin bad++; $display("FAIL b2b_a_out2 got=%0d exp=12", got[2]); end
      total++; if (got[3] !== 6'd7) begin bad++; $display("FAIL b2b_a_out3 got=%0d exp=7", got[3]); end
      $display("test_back_to_back A: out=%0d,%0d,%0d,%0d", got[0], got[1], got[2], got[3]);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
      load4(6'd33, 6'd2, 6'd61, 6'd18);
      run_sort(1'b0, '0);
      total++; if (lat !== 10) begin bad++; $display("FAIL b2b_latency got=%0d exp=10", lat); end
      drain(4'b1111);
      total++; if (got[0] !== 6'd61) begin bad++; $display("FAIL b2b_b_out0 got=%0d exp=61", got[0]); end
      total++; if (got[1] !== 6'd33) begin bad++; $display("FAIL b2b_b_out1 got=%0d exp=33", got[1]); end
      total++; if (got[2] !== 6'd18) begin bad++; $display("FAIL b2b_b_out2 got=%0d exp=18", got[2]); end
      total++; if (got[3] !== 6'd2) begin bad++; $display("FAIL b2b_b_out3 got=%0d exp=2", got[3]); end
      @(negedge clk);
      $display("test_back_to_back B: out=%0d,%0d,%0d,%0d", got[0], got[1], got[2], got[3]);
   endtask

   initial begin
      test_reset();
      test_batch("basic",   6'd3,  6'd60, 6'd0,  6'd60, 6'd60, 6'd60, 6'd3,  6'd0);
      test_batch("borrow",  6'd0,  6'd63, 6'd63, 6'd0,  6'd63, 6'd63, 6'd0,  6'd0);
      test_batch("sorted",  6'd50, 6'd40, 6'd30, 6'd20, 6'd50, 6'd40, 6'd30, 6'd20);
      test_batch("reverse", 6'd1,  6'd2,  6'd3,  6'd4,  6'd4,  6'd3,  6'd2,  6'd1);
      test_stall();
      test_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
